// File: rtl/stopwatch_ctrl_if.sv
// Command/status bundle between the stopwatch mode sequencer and board I/O /
// MM:SS counter. The slave modport is the sequencer side.
interface stopwatch_ctrl_if;
  logic       ONE_CLK;
  logic       TWO_CLK;
  logic       ADJ;
  logic       SEL;
  logic       PAUSE_BTN;
  logic       CLR_BTN;
  logic       LAP_BTN;
  logic       INC_SEC;
  logic       INC_MIN;
  logic       CLR;
  logic       BLANK;
  logic       LAP;
  logic [1:0] STATE;

  modport master (
    output ONE_CLK, TWO_CLK, ADJ, SEL, PAUSE_BTN, CLR_BTN, LAP_BTN,
    input  INC_SEC, INC_MIN, CLR, BLANK, LAP, STATE
  );

  modport slave (
    input  ONE_CLK, TWO_CLK, ADJ, SEL, PAUSE_BTN, CLR_BTN, LAP_BTN,
    output INC_SEC, INC_MIN, CLR, BLANK, LAP, STATE
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: button debounce, RUN/PAUSE/ADJUST FSM, one-cycle
// counter commands and adjust blink. Define CTRL_LAP_EN to enable the lap hold.
module stopwatch_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned DB_CNT_W  = 20
) (
  input logic             M_CLK,
  input logic             RESET,
  stopwatch_ctrl_if.slave bus
);

  localparam int unsigned BTN_PAUSE = 0;
  localparam int unsigned BTN_CLR   = 1;
`ifdef CTRL_LAP_EN
  localparam int unsigned BTN_LAP   = 2;
  localparam int unsigned N_BTN     = 3;
`else
  localparam int unsigned N_BTN     = 2;
`endif
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_ADJUST = 2'b11
  } state_t;

  logic [N_BTN-1:0]    btn_raw;
  logic [N_BTN-1:0]    btn_s1;
  logic [N_BTN-1:0]    btn_s2;
  logic [N_BTN-1:0]    btn_acc;
  logic [N_BTN-1:0]    btn_press;
  logic [DB_CNT_W-1:0] db_cnt [N_BTN];

  logic   adj_s1, adj_s2;
  logic   sel_s1, sel_s2;
  logic   pause_press, clr_press;
  state_t state_q;
  logic   inc_sec_q, inc_min_q, clr_q, blank_q, lap_q;

`ifdef CTRL_LAP_EN
  logic lap_press;
  assign btn_raw   = {bus.LAP_BTN, bus.CLR_BTN, bus.PAUSE_BTN};
  assign lap_press = btn_press[BTN_LAP];
`else
  logic unused_lap_btn;
  assign btn_raw        = {bus.CLR_BTN, bus.PAUSE_BTN};
  assign unused_lap_btn = bus.LAP_BTN;
`endif

  assign pause_press = btn_press[BTN_PAUSE];
  assign clr_press   = btn_press[BTN_CLR];

  // Level synchronisers for the adjust switch and select.
  always_ff @(posedge M_CLK) begin
    if (RESET) begin
      adj_s1 <= 1'b0;
      adj_s2 <= 1'b0;
      sel_s1 <= 1'b0;
      sel_s2 <= 1'b0;
    end else begin
      adj_s1 <= bus.ADJ;
      adj_s2 <= adj_s1;
      sel_s1 <= bus.SEL;
      sel_s2 <= sel_s1;
    end
  end

  // Button sync + debounce; any return to the accepted level restarts the count.
  always_ff @(posedge M_CLK) begin
    if (RESET) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_acc   <= '0;
      btn_press <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        btn_press[i] <= 1'b0;
        if (btn_s2[i] == btn_acc[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]    <= '0;
          btn_acc[i]   <= btn_s2[i];
          btn_press[i] <= btn_s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  // Mode FSM with registered one-cycle commands; clear always beats increments.
  always_ff @(posedge M_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      clr_q     <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      inc_sec_q <= 1'b0;
      inc_min_q <= 1'b0;
      clr_q     <= 1'b0;
      if (adj_s2) begin
        if (state_q != ST_ADJUST) begin
          state_q <= ST_ADJUST;
          blank_q <= 1'b0;
        end else begin
          if (clr_press) begin
            clr_q <= 1'b1;
          end else if (bus.TWO_CLK) begin
            inc_min_q <= ~sel_s2;
            inc_sec_q <= sel_s2;
          end
          if (bus.TWO_CLK) begin
            blank_q <= ~blank_q;
          end
        end
      end else if (state_q == ST_ADJUST) begin
        // Adjusted time is held; the user restarts it explicitly.
        state_q <= ST_PAUSE;
        blank_q <= 1'b0;
        clr_q   <= clr_press;
      end else if (clr_press) begin
        state_q <= ST_IDLE;
        clr_q   <= 1'b1;
      end else begin
        if (pause_press) begin
          case (state_q)
            ST_IDLE:  state_q <= ST_RUN;
            ST_RUN:   state_q <= ST_PAUSE;
            ST_PAUSE: state_q <= ST_RUN;
            default:  state_q <= state_q;
          endcase
        end
        if (state_q == ST_RUN && bus.ONE_CLK && !pause_press) begin
          inc_sec_q <= 1'b1;
        end
      end
    end
  end

`ifdef CTRL_LAP_EN
  // Lap hold: toggled only in RUN, dropped on clear and on ADJUST entry.
  always_ff @(posedge M_CLK) begin
    if (RESET) begin
      lap_q <= 1'b0;
    end else if (adj_s2) begin
      if (state_q != ST_ADJUST) begin
        lap_q <= 1'b0;
      end
    end else if (state_q != ST_ADJUST) begin
      if (clr_press) begin
        lap_q <= 1'b0;
      end else if (state_q == ST_RUN && lap_press) begin
        lap_q <= ~lap_q;
      end
    end
  end
`else
  assign lap_q = 1'b0;
`endif

  assign bus.INC_SEC = inc_sec_q;
  assign bus.INC_MIN = inc_min_q;
  assign bus.CLR     = clr_q;
  assign bus.BLANK   = blank_q;
  assign bus.LAP     = lap_q;
  assign bus.STATE   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4; LAP expectations follow
// whether CTRL_LAP_EN is defined for the build.
module tb_stopwatch_ctrl;

  localparam int unsigned DB_CYCLES = 4;
  localparam int unsigned DB_CNT_W  = 3;
`ifdef CTRL_LAP_EN
  localparam int LAP_ON = 1;
`else
  localparam int LAP_ON = 0;
`endif

  logic M_CLK;
  logic RESET;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .DB_CYCLES (DB_CYCLES),
    .DB_CNT_W  (DB_CNT_W)
  ) dut (
    .M_CLK (M_CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial M_CLK = 1'b0;
  always #5 M_CLK = ~M_CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int n_inc_sec = 0;
  int n_inc_min = 0;
  int n_clr     = 0;
  int n_multi   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock; outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge M_CLK);
    #1;
    if (bus.INC_SEC) n_inc_sec++;
    if (bus.INC_MIN) n_inc_min++;
    if (bus.CLR)     n_clr++;
    if (32'(bus.INC_SEC) + 32'(bus.INC_MIN) + 32'(bus.CLR) > 1) n_multi++;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    n_inc_sec = 0;
    n_inc_min = 0;
    n_clr     = 0;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       bus.PAUSE_BTN = v;
      1:       bus.CLR_BTN   = v;
      default: bus.LAP_BTN   = v;
    endcase
  endtask

  // Clean press long enough to be accepted, then a settled release.
  task automatic press_btn(input int which);
    set_btn(which, 1'b1);
    cyc(6);
    set_btn(which, 1'b0);
    cyc(8);
  endtask

  task automatic strobe_one();
    bus.ONE_CLK = 1'b1;
    tick();
    bus.ONE_CLK = 1'b0;
  endtask

  initial begin
    RESET         = 1'b1;
    bus.ONE_CLK   = 1'b0;
    bus.TWO_CLK   = 1'b0;
    bus.ADJ       = 1'b0;
    bus.SEL       = 1'b0;
    bus.PAUSE_BTN = 1'b0;
    bus.CLR_BTN   = 1'b0;
    bus.LAP_BTN   = 1'b0;
    cyc(3);
    check("rst_state", 32'(bus.STATE), 32'd0);
    check("rst_outs", 32'({bus.INC_SEC, bus.INC_MIN, bus.CLR, bus.BLANK, bus.LAP}), 32'd0);
    RESET = 1'b0;
    cyc(2);

    // 1: start, then three 1 Hz strobes with exact one-cycle latency
    press_btn(0);
    check("t1_run", 32'(bus.STATE), 32'd1);
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      bus.ONE_CLK = 1'b1;
      check("t1_pre", 32'(bus.INC_SEC), 32'd0);
      tick();
      bus.ONE_CLK = 1'b0;
      check("t1_lat", 32'(bus.INC_SEC), 32'd1);
      tick();
      check("t1_width", 32'(bus.INC_SEC), 32'd0);
      cyc(3);
    end
    check("t1_count", 32'(n_inc_sec), 32'd3);

    // 2: bouncing button rejected; clean press pauses and drops coincident strobe
    for (int k = 0; k < 2; k++) begin
      bus.PAUSE_BTN = 1'b1;
      cyc(2);
      bus.PAUSE_BTN = 1'b0;
      cyc(2);
    end
    cyc(8);
    check("t2_bounce", 32'(bus.STATE), 32'd1);
    clear_counts();
    bus.PAUSE_BTN = 1'b1;
    cyc(6);
    check("t2_pre", 32'(bus.STATE), 32'd1);
    bus.ONE_CLK   = 1'b1;
    bus.PAUSE_BTN = 1'b0;
    tick();
    bus.ONE_CLK = 1'b0;
    check("t2_pause", 32'(bus.STATE), 32'd2);
    check("t2_drop", 32'(bus.INC_SEC), 32'd0);
    cyc(8);
    strobe_one();
    cyc(3);
    check("t2_noinc", 32'(n_inc_sec), 32'd0);

    // 3: adjust minutes with blink, then seconds, clear in adjust, exit to PAUSE
    bus.ADJ = 1'b1;
    cyc(4);
    check("t3_adj", 32'(bus.STATE), 32'd3);
    check("t3_blank0", 32'(bus.BLANK), 32'd0);
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      bus.TWO_CLK = 1'b1;
      tick();
      bus.TWO_CLK = 1'b0;
      check("t3_incmin", 32'(bus.INC_MIN), 32'd1);
      check("t3_blank", 32'(bus.BLANK), (k % 2 == 0) ? 32'd1 : 32'd0);
      cyc(2);
    end
    check("t3_nmin", 32'(n_inc_min), 32'd4);
    check("t3_nsec", 32'(n_inc_sec), 32'd0);
    bus.SEL = 1'b1;
    cyc(3);
    bus.TWO_CLK = 1'b1;
    tick();
    bus.TWO_CLK = 1'b0;
    check("t3_selsec", 32'({bus.INC_SEC, bus.INC_MIN}), 32'b10);
    check("t3_blank5", 32'(bus.BLANK), 32'd1);
    cyc(2);
    press_btn(1);
    check("t3_clr_cnt", 32'(n_clr), 32'd1);
    check("t3_clr_stay", 32'(bus.STATE), 32'd3);
    bus.ADJ = 1'b0;
    bus.SEL = 1'b0;
    cyc(4);
    check("t3_exit", 32'(bus.STATE), 32'd2);
    check("t3_blankoff", 32'(bus.BLANK), 32'd0);

    // 4: clear and pause accepted together with a 1 Hz strobe in RUN
    press_btn(0);
    check("t4_run", 32'(bus.STATE), 32'd1);
    clear_counts();
    bus.CLR_BTN   = 1'b1;
    bus.PAUSE_BTN = 1'b1;
    cyc(6);
    bus.ONE_CLK   = 1'b1;
    bus.CLR_BTN   = 1'b0;
    bus.PAUSE_BTN = 1'b0;
    tick();
    bus.ONE_CLK = 1'b0;
    check("t4_clr", 32'(bus.CLR), 32'd1);
    check("t4_noinc", 32'(bus.INC_SEC), 32'd0);
    check("t4_idle", 32'(bus.STATE), 32'd0);
    tick();
    check("t4_clrw", 32'(bus.CLR), 32'd0);
    cyc(8);
    check("t4_stay", 32'(bus.STATE), 32'd0);
    check("t4_nclr", 32'(n_clr), 32'd1);

    // 5: lap hold in RUN, counting continues, clear drops it
    press_btn(0);
    clear_counts();
    press_btn(2);
    check("t5_lap", 32'(bus.LAP), 32'(LAP_ON));
    strobe_one();
    cyc(2);
    check("t5_inc", 32'(n_inc_sec), 32'd1);
    check("t5_state", 32'(bus.STATE), 32'd1);
    press_btn(1);
    check("t5_lapclr", 32'(bus.LAP), 32'd0);
    check("t5_idle", 32'(bus.STATE), 32'd0);

    // 6: reset in ADJUST with BLANK high, also discarding a half-debounced press
    bus.ADJ = 1'b1;
    cyc(4);
    bus.TWO_CLK = 1'b1;
    tick();
    bus.TWO_CLK = 1'b0;
    check("t6_blank", 32'(bus.BLANK), 32'd1);
    tick();
    bus.PAUSE_BTN = 1'b1;
    cyc(3);
    RESET   = 1'b1;
    bus.ADJ = 1'b0;
    tick();
    check("t6_state", 32'(bus.STATE), 32'd0);
    check("t6_outs", 32'({bus.INC_SEC, bus.INC_MIN, bus.CLR, bus.BLANK, bus.LAP}), 32'd0);
    bus.PAUSE_BTN = 1'b0;
    RESET         = 1'b0;
    cyc(12);
    check("t6_nopress", 32'(bus.STATE), 32'd0);

    check("exclusive", 32'(n_multi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
